rv_memory: RTL and testbench

// - Memory pipeline stage; consumes the execute-stage outputs (ALU result, rs2 value, funct3, rd, controls).
// - Registers them, issues aligned load/store transactions on a req/ack data bus, and stalls the pipeline while an access is pending.
// - Presents aligned, extended load data and forwarded controls to the write stage.
// - Drives the ALU-result bypass value back to execute.

---
 rtl/rv_memory_if.sv | 21 ++
 rtl/rv_memory.sv | 210 +++++++++++++++++++++
 tb/tb_rv_memory.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_memory_if.sv
// Data-bus bundle between the memory stage and the data memory.
// Request is held until ack; rdata is valid in the ack cycle.
interface rv_memory_if;
  logic        req;
  logic        we;
  logic [29:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/rv_memory.sv
// Memory pipeline stage: registers execute outputs, runs aligned
// load/store accesses on the req/ack bus and stalls while pending.
module rv_memory #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_flush,
  input  logic        i_stall,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_rs2_val,
  input  logic [4:0]  i_rd,
  input  logic [29:0] i_pc_p4,
  input  logic [1:0]  i_res_src,
  input  logic [2:0]  i_funct3,
  input  logic        i_reg_write,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  rv_memory_if.master dbus,
  output logic        o_stall_req,
  output logic [31:0] o_memory_rd_val,
  output logic [31:0] o_alu_result,
  output logic [31:0] o_load_data,
  output logic        o_reg_write,
  output logic [4:0]  o_rd,
  output logic [1:0]  o_res_src,
  output logic [29:0] o_pc_p4,
  output logic        o_misalign,
  output logic        o_bus_err
);

  localparam int CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam int unsigned TO_LAST_I =
    (BUS_TIMEOUT == 0) ? 0 : BUS_TIMEOUT - 1;
  localparam logic [CW-1:0] TO_LAST = TO_LAST_I[CW-1:0];
  localparam bit TO_EN = (BUS_TIMEOUT != 0);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state, state_d;

  logic [31:0] r_alu_result;
  logic [31:0] r_rs2;
  logic [4:0]  r_rd;
  logic [29:0] r_pc_p4;
  logic [1:0]  r_res_src;
  logic [2:0]  r_funct3;
  logic        r_reg_write;
  logic        r_mem_read;
  logic        r_mem_write;
  logic        r_misalign;
  logic        r_bus_err;
  logic [31:0] r_rdata;
  logic [CW-1:0] r_cnt;

  logic capture;
  logic mem_op_i;
  logic misalign_i;
  logic bad_f3;
  logic ack_hit;
  logic timeout_hit;
  logic in_access;

  assign in_access = (state == ACCESS);
  assign capture   = ~i_flush & ~i_stall & ~in_access;
  assign mem_op_i  = i_mem_read | i_mem_write;

  // funct3 3/6/7 is not a legal width for any memory op
  assign bad_f3 = (i_funct3 == 3'd3) | (i_funct3[2:1] == 2'b11);

  always_comb begin
    misalign_i = 1'b0;
    unique case (1'b1)
      bad_f3:
        misalign_i = 1'b1;
      i_funct3[1:0] == 2'b01:
        misalign_i = i_alu_result[0];
      i_funct3[1:0] == 2'b10:
        misalign_i = |i_alu_result[1:0];
      default:
        misalign_i = 1'b0;
    endcase
    misalign_i = misalign_i & mem_op_i;
  end

  assign ack_hit     = in_access & dbus.ack;
  assign timeout_hit = in_access & ~dbus.ack & TO_EN
                     & (r_cnt == TO_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (i_flush) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE:
          if (capture && mem_op_i && !misalign_i)
            state_d = ACCESS;
        ACCESS:
          if (ack_hit || timeout_hit)
            state_d = IDLE;
        default:
          state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_flush) begin
      r_alu_result <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_pc_p4      <= '0;
      r_res_src    <= '0;
      r_funct3     <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_misalign   <= 1'b0;
      r_bus_err    <= 1'b0;
      r_rdata      <= '0;
      r_cnt        <= '0;
    end else if (capture) begin
      r_alu_result <= i_alu_result;
      r_rs2        <= i_rs2_val;
      r_rd         <= i_rd;
      r_pc_p4      <= i_pc_p4;
      r_res_src    <= i_res_src;
      r_funct3     <= i_funct3;
      r_reg_write  <= i_reg_write;
      r_mem_read   <= i_mem_read;
      r_mem_write  <= i_mem_write;
      r_misalign   <= misalign_i;
      r_bus_err    <= 1'b0;
      r_rdata      <= '0;
      r_cnt        <= '0;
    end else if (in_access) begin
      r_cnt <= r_cnt + 1'b1;
      if (ack_hit) begin
        r_rdata <= dbus.rdata;
      end else if (timeout_hit) begin
        r_bus_err <= 1'b1;
        r_rdata   <= '0;
      end
    end
  end

  logic [1:0]  a;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic        sx;

  assign a    = r_alu_result[1:0];
  assign ld_b = r_rdata[{a, 3'b000} +: 8];
  assign ld_h = a[1] ? r_rdata[31:16] : r_rdata[15:0];
  assign sx   = ~r_funct3[2];

  always_comb begin
    o_load_data = '0;
    if (r_mem_read) begin
      unique case (r_funct3[1:0])
        2'b00:   o_load_data = {{24{sx & ld_b[7]}}, ld_b};
        2'b01:   o_load_data = {{16{sx & ld_h[15]}}, ld_h};
        2'b10:   o_load_data = r_rdata;
        default: o_load_data = '0;
      endcase
    end
  end

  always_comb begin
    dbus.be    = '0;
    dbus.wdata = r_rs2;
    unique case (r_funct3[1:0])
      2'b00: begin
        dbus.be    = 4'b0001 << a;
        dbus.wdata = {4{r_rs2[7:0]}};
      end
      2'b01: begin
        dbus.be    = 4'b0011 << {a[1], 1'b0};
        dbus.wdata = {2{r_rs2[15:0]}};
      end
      2'b10:   dbus.be = 4'hF;
      default: dbus.be = '0;
    endcase
    if (r_mem_read)
      dbus.be = 4'hF;
    else if (!r_mem_write)
      dbus.be = '0;
  end

  assign dbus.req  = in_access;
  assign dbus.we   = r_mem_write;
  assign dbus.addr = r_alu_result[31:2];

  assign o_stall_req     = in_access;
  assign o_memory_rd_val = r_alu_result;
  assign o_alu_result    = r_alu_result;
  assign o_reg_write     = r_reg_write & ~r_misalign & ~r_bus_err;
  assign o_rd            = r_rd;
  assign o_res_src       = r_res_src;
  assign o_pc_p4         = r_pc_p4;
  assign o_misalign      = r_misalign;
  assign o_bus_err       = r_bus_err;

endmodule

// File: tb/tb_rv_memory.sv
// Scenario bench for rv_memory with a scripted ack bus model
// and a queue of expected results.
module tb_rv_memory;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        stall;
  logic [31:0] alu_result;
  logic [31:0] rs2_val;
  logic [4:0]  rd;
  logic [29:0] pc_p4;
  logic [1:0]  res_src;
  logic [2:0]  funct3;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        stall_req;
  logic [31:0] memory_rd_val;
  logic [31:0] o_alu;
  logic [31:0] load_data;
  logic        o_rw;
  logic [4:0]  o_rd;
  logic [1:0]  o_res;
  logic [29:0] o_pc;
  logic        misalign;
  logic        bus_err;

  rv_memory_if dbus ();

  rv_memory #(.BUS_TIMEOUT(4)) dut (
    .i_clk           (clk),
    .i_reset_n       (reset_n),
    .i_flush         (flush),
    .i_stall         (stall),
    .i_alu_result    (alu_result),
    .i_rs2_val       (rs2_val),
    .i_rd            (rd),
    .i_pc_p4         (pc_p4),
    .i_res_src       (res_src),
    .i_funct3        (funct3),
    .i_reg_write     (reg_write),
    .i_mem_read      (mem_read),
    .i_mem_write     (mem_write),
    .dbus            (dbus),
    .o_stall_req     (stall_req),
    .o_memory_rd_val (memory_rd_val),
    .o_alu_result    (o_alu),
    .o_load_data     (load_data),
    .o_reg_write     (o_rw),
    .o_rd            (o_rd),
    .o_res_src       (o_res),
    .o_pc_p4         (o_pc),
    .o_misalign      (misalign),
    .o_bus_err       (bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  int          nreq, nst;
  logic        s_we;
  logic [3:0]  s_be;
  logic [31:0] s_wd;
  logic [29:0] s_addr;
  logic        done;
  logic [31:0] e;

  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3, input logic mr,
                       input logic mw, input logic rw,
                       input logic [4:0] r);
    alu_result = a; rs2_val = d; funct3 = f3;
    mem_read = mr; mem_write = mw; reg_write = rw; rd = r;
    pc_p4 = 30'h0ABCDE; res_src = 2'd1;
    @(posedge clk); #1;
    alu_result = '0; rs2_val = '0; funct3 = '0;
    mem_read = 0; mem_write = 0; reg_write = 0; rd = '0;
    pc_p4 = '0; res_src = '0;
  endtask

  // bus model: ack on the ack_at-th request cycle (0 = never)
  task automatic run_access(input int ack_at, input logic [31:0] rdat);
    nreq = 0; nst = 0; done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stall_req) nst++;
      if (dbus.req) begin
        nreq++;
        if (nreq == 1) begin
          s_we = dbus.we; s_be = dbus.be;
          s_wd = dbus.wdata; s_addr = dbus.addr;
        end
        if (ack_at != 0 && nreq == ack_at) begin
          dbus.ack = 1; dbus.rdata = rdat;
        end
      end else begin
        dbus.ack = 0; dbus.rdata = '0;
        done = 1;
        break;
      end
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL access_bound: done=%0d required 1", done);
    end
  endtask

  task automatic test_reset;
    reset_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({dbus.req, stall_req, o_rw, misalign, bus_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 00000",
               {dbus.req, stall_req, o_rw, misalign, bus_err});
    end
    n_cmp++;
    if ({o_alu, load_data, dbus.wdata} !== 96'b0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h required 0",
               o_alu, load_data, dbus.wdata);
    end
    n_cmp++;
    if ({dbus.be, o_rd, o_pc, o_res} !== 41'b0) begin
      n_fail++;
      $display("FAIL reset_misc: be=%h rd=%h pc=%h res=%h required 0",
               dbus.be, o_rd, o_pc, o_res);
    end
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_load_word;
    exp_q.push_back(32'hDEADBEEF);
    issue(32'h100, 0, 3'd2, 1, 0, 1, 5'd9);
    run_access(3, 32'hDEADBEEF);
    n_cmp++;
    if (nreq != 3 || nst != 3) begin
      n_fail++;
      $display("FAIL lw_latency: req=%0d stall=%0d required 3/3", nreq, nst);
    end
    n_cmp++;
    if (s_addr !== 30'h40 || s_be !== 4'hF || s_we !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_bus: addr=%h be=%h we=%b required 40/f/0",
               s_addr, s_be, s_we);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (load_data !== e) begin
      n_fail++;
      $display("FAIL lw_data: got %h required %h", load_data, e);
    end
    n_cmp++;
    if (o_rw !== 1'b1 || o_rd !== 5'd9 || o_pc !== 30'h0ABCDE
        || o_res !== 2'd1 || memory_rd_val !== 32'h100) begin
      n_fail++;
      $display("FAIL lw_pass: rw=%b rd=%0d pc=%h res=%0d byp=%h",
               o_rw, o_rd, o_pc, o_res, memory_rd_val);
    end
  endtask

  task automatic test_load_ext;
    logic [31:0] addrs[3];
    logic [2:0]  f3s[3];
    addrs = '{32'h103, 32'h103, 32'h102};
    f3s   = '{3'd0, 3'd4, 3'd5};
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(k == 0 ? 32'hFFFFFF80 :
                      k == 1 ? 32'h00000080 : 32'h000080FF);
      issue(addrs[k], 0, f3s[k], 1, 0, 1, 5'd3);
      run_access(1, 32'h80FFFFFF);
      e = exp_q.pop_front();
      n_cmp++;
      if (load_data !== e || nst != 1) begin
        n_fail++;
        $display("FAIL load_ext%0d: got %h stall=%0d required %h/1",
                 k, load_data, nst, e);
      end
    end
  endtask

  task automatic test_store;
    exp_q.push_back(32'h78787878);
    exp_q.push_back(32'h2);
    issue(32'h201, 32'h12345678, 3'd0, 0, 1, 0, 5'd0);
    run_access(1, 0);
    e = exp_q.pop_front();
    n_cmp++;
    if (s_wd !== e || s_we !== 1'b1 || s_addr !== 30'h80) begin
      n_fail++;
      $display("FAIL sb_data: wd=%h we=%b addr=%h required %h/1/80",
               s_wd, s_we, s_addr, e);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (s_be !== e[3:0]) begin
      n_fail++;
      $display("FAIL sb_be: got %b required %b", s_be, e[3:0]);
    end
    exp_q.push_back(32'h56785678);
    exp_q.push_back(32'hC);
    issue(32'h202, 32'h12345678, 3'd1, 0, 1, 0, 5'd0);
    run_access(2, 0);
    e = exp_q.pop_front();
    n_cmp++;
    if (s_wd !== e || s_we !== 1'b1 || nreq != 2) begin
      n_fail++;
      $display("FAIL sh_data: wd=%h we=%b req=%0d required %h/1/2",
               s_wd, s_we, nreq, e);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (s_be !== e[3:0]) begin
      n_fail++;
      $display("FAIL sh_be: got %b required %b", s_be, e[3:0]);
    end
  endtask

  task automatic test_misalign;
    issue(32'h102, 0, 3'd2, 1, 0, 1, 5'd4);
    run_access(1, 32'h55555555);
    n_cmp++;
    if (nreq != 0 || misalign !== 1'b1 || o_rw !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign: req=%0d mis=%b rw=%b required 0/1/0",
               nreq, misalign, o_rw);
    end
    issue(32'h100, 0, 3'd7, 0, 1, 0, 5'd0);
    n_cmp++;
    if (misalign !== 1'b1 || stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_funct3: mis=%b stall=%b required 1/0",
               misalign, stall_req);
    end
    exp_q.push_back(32'hCAFEF00D);
    issue(32'h104, 0, 3'd2, 1, 0, 1, 5'd4);
    n_cmp++;
    if (misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_clear: got %b required 0", misalign);
    end
    run_access(1, 32'hCAFEF00D);
    e = exp_q.pop_front();
    n_cmp++;
    if (load_data !== e || o_rw !== 1'b1) begin
      n_fail++;
      $display("FAIL after_misalign: got %h rw=%b required %h/1",
               load_data, o_rw, e);
    end
  endtask

  task automatic test_timeout;
    exp_q.push_back(32'h0);
    issue(32'h300, 0, 3'd2, 1, 0, 1, 5'd5);
    run_access(0, 0);
    e = exp_q.pop_front();
    n_cmp++;
    if (nreq != 4 || bus_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout: req=%0d err=%b required 4/1", nreq, bus_err);
    end
    n_cmp++;
    if (load_data !== e || stall_req !== 1'b0 || o_rw !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_out: data=%h stall=%b rw=%b required %h/0/0",
               load_data, stall_req, o_rw, e);
    end
  endtask

  task automatic test_flush;
    issue(32'h400, 0, 3'd2, 1, 0, 1, 5'd6);
    @(negedge clk);
    @(negedge clk);
    nreq = dbus.req;
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    n_cmp++;
    if (nreq != 1 || dbus.req !== 1'b0 || stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_req: before=%0d req=%b stall=%b required 1/0/0",
               nreq, dbus.req, stall_req);
    end
    n_cmp++;
    if (o_rw !== 1'b0 || o_alu !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_bubble: rw=%b alu=%h required 0/0", o_rw, o_alu);
    end
  endtask

  task automatic test_reset_mid;
    issue(32'h500, 32'h77, 3'd2, 1, 0, 1, 5'd7);
    @(negedge clk);
    reset_n = 0;
    dbus.ack = 1; dbus.rdata = 32'h11111111;
    @(posedge clk); #1;
    dbus.ack = 0; dbus.rdata = '0;
    @(negedge clk);
    n_cmp++;
    if ({dbus.req, stall_req, o_rw, misalign, bus_err} !== 5'b0
        || {o_alu, load_data} !== 64'b0 || o_rd !== 5'd0
        || o_pc !== 30'd0 || dbus.be !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid: req=%b alu=%h data=%h rd=%0d be=%h",
               dbus.req, o_alu, load_data, o_rd, dbus.be);
    end
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_hold;
    exp_q.push_back(32'hA5A55A5A);
    issue(32'h600, 0, 3'd2, 1, 0, 1, 5'd8);
    run_access(1, 32'hA5A55A5A);
    stall = 1;
    nreq = 0;
    repeat (3) begin
      @(negedge clk);
      if (dbus.req) nreq++;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (nreq != 0 || load_data !== e || o_rw !== 1'b1) begin
      n_fail++;
      $display("FAIL hold: req=%0d data=%h rw=%b required 0/%h/1",
               nreq, load_data, o_rw, e);
    end
    stall = 0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 0; flush = 0; stall = 0;
    alu_result = '0; rs2_val = '0; rd = '0; pc_p4 = '0;
    res_src = '0; funct3 = '0;
    reg_write = 0; mem_read = 0; mem_write = 0;
    dbus.ack = 0; dbus.rdata = '0;
    test_reset;
    test_load_word;
    test_load_ext;
    test_store;
    test_misalign;
    test_timeout;
    test_flush;
    test_reset_mid;
    test_hold;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
